// File: rtl/lcd_position_set_if.sv
// Byte bus between the position-setting stage and the LCD byte driver.
// Valid/ready: a byte moves on a cycle with wr_req=1 and wr_ready=1; while wr_req=1
// and wr_ready=0 the master holds wr_req, wr_dc and wr_data stable.
interface lcd_position_set_if;
  logic       wr_req;
  logic       wr_dc;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_req, output wr_dc, output wr_data, input wr_ready);
  modport slave  (input wr_req, input wr_dc, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_position_set.sv
// Latches a drawing window on the rising edge of position_en and emits the
// CASET / RASET / RAMWR window sequence one byte at a time, then pulses position_finish.
module lcd_position_set #(
  parameter int          H_RES     = 240,
  parameter int          V_RES     = 320,
  parameter int          COORD_W   = 16,
  parameter logic [7:0]  CMD_CASET = 8'h2A,
  parameter logic [7:0]  CMD_RASET = 8'h2B,
  parameter logic [7:0]  CMD_RAMWR = 8'h2C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               position_en,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] x_end,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] y_end,
  lcd_position_set_if.master wr,
  output logic               busy,
  output logic               position_finish,
  output logic [31:0]        pix_total,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SEND, S_DONE} state_t;

  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_RES - 1);
  localparam logic [3:0]         LAST_IDX = 4'd10;

  state_t             state_q, state_n;
  logic               en_q;
  logic [COORD_W-1:0] xs_raw, xe_raw, ys_raw, ye_raw;
  logic [15:0]        xs_q, xe_q, ys_q, ye_q;
  logic [15:0]        xs_n, xe_n, ys_n, ye_n;
  logic [3:0]         idx_q, idx_n;
  logic               req_q, req_n, dc_q, dc_n, fin_n;
  logic [7:0]         data_q, data_n;
  logic [31:0]        pix_n, pix_calc, w_x, w_y;
  logic               capture, norm_load;
  logic [8:0]         next_byte;

  function automatic logic [15:0] clamp16(input logic [COORD_W-1:0] v,
                                          input logic [COORD_W-1:0] lim);
    return 16'((v > lim) ? lim : v);
  endfunction

  // {dc, data} for sequence position i, built from the normalised window
  function automatic logic [8:0] byte_sel(input logic [3:0] i,
                                          input logic [15:0] xs, input logic [15:0] xe,
                                          input logic [15:0] ys, input logic [15:0] ye);
    case (i)
      4'd0:    return {1'b0, CMD_CASET};
      4'd1:    return {1'b1, xs[15:8]};
      4'd2:    return {1'b1, xs[7:0]};
      4'd3:    return {1'b1, xe[15:8]};
      4'd4:    return {1'b1, xe[7:0]};
      4'd5:    return {1'b0, CMD_RASET};
      4'd6:    return {1'b1, ys[15:8]};
      4'd7:    return {1'b1, ys[7:0]};
      4'd8:    return {1'b1, ye[15:8]};
      4'd9:    return {1'b1, ye[7:0]};
      default: return {1'b0, CMD_RAMWR};
    endcase
  endfunction

  // Swap reversed bounds first, then clamp each to the panel edge
  always_comb begin
    xs_n = clamp16((xs_raw > xe_raw) ? xe_raw : xs_raw, X_MAX);
    xe_n = clamp16((xs_raw > xe_raw) ? xs_raw : xe_raw, X_MAX);
    ys_n = clamp16((ys_raw > ye_raw) ? ye_raw : ys_raw, Y_MAX);
    ye_n = clamp16((ys_raw > ye_raw) ? ys_raw : ye_raw, Y_MAX);
    w_x  = {16'd0, xe_n} - {16'd0, xs_n} + 32'd1;
    w_y  = {16'd0, ye_n} - {16'd0, ys_n} + 32'd1;
    pix_calc = w_x * w_y;
  end

  assign next_byte = byte_sel(idx_q + 4'd1, xs_q, xe_q, ys_q, ye_q);

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    req_n     = req_q;
    dc_n      = dc_q;
    data_n    = data_q;
    fin_n     = 1'b0;
    pix_n     = pix_total;
    capture   = 1'b0;
    norm_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (position_en && !en_q) begin
          capture = 1'b1;
          state_n = S_LATCH;
        end
      end
      S_LATCH: begin
        norm_load = 1'b1;
        pix_n     = pix_calc;
        state_n   = S_SEND;
        idx_n     = 4'd0;
        req_n     = 1'b1;
        dc_n      = 1'b0;
        data_n    = CMD_CASET;
      end
      S_SEND: begin
        // Decisions happen only on a transfer so an offered byte is never withdrawn
        if (req_q && wr.wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_n = S_DONE;
            req_n   = 1'b0;
            dc_n    = 1'b0;
            data_n  = 8'h00;
            fin_n   = 1'b1;
          end else if (!position_en) begin
            state_n = S_IDLE;
            req_n   = 1'b0;
            dc_n    = 1'b0;
            data_n  = 8'h00;
          end else begin
            idx_n          = idx_q + 4'd1;
            {dc_n, data_n} = next_byte;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      en_q            <= 1'b0;
      idx_q           <= 4'd0;
      req_q           <= 1'b0;
      dc_q            <= 1'b0;
      data_q          <= 8'h00;
      busy            <= 1'b0;
      position_finish <= 1'b0;
      pix_total       <= 32'd0;
      xs_raw          <= '0;
      xe_raw          <= '0;
      ys_raw          <= '0;
      ye_raw          <= '0;
      xs_q            <= 16'd0;
      xe_q            <= 16'd0;
      ys_q            <= 16'd0;
      ye_q            <= 16'd0;
    end else begin
      state_q         <= state_n;
      en_q            <= position_en;
      idx_q           <= idx_n;
      req_q           <= req_n;
      dc_q            <= dc_n;
      data_q          <= data_n;
      busy            <= (state_n != S_IDLE);
      position_finish <= fin_n;
      pix_total       <= pix_n;
      if (capture) begin
        xs_raw <= x_start;
        xe_raw <= x_end;
        ys_raw <= y_start;
        ye_raw <= y_end;
      end
      if (norm_load) begin
        xs_q <= xs_n;
        xe_q <= xe_n;
        ys_q <= ys_n;
        ye_q <= ye_n;
      end
    end
  end

  assign wr.wr_req  = req_q;
  assign wr.wr_dc   = dc_q;
  assign wr.wr_data = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_position_set.sv
// Directed bench for lcd_position_set: window bytes, stalls, abort, reset and retrigger.
module tb_lcd_position_set;

  logic        clk = 1'b0;
  logic        rst;
  logic        position_en;
  logic [15:0] x_start, x_end, y_start, y_end;
  logic        busy, position_finish;
  logic [31:0] pix_total;
  logic [1:0]  dbg_state;

  lcd_position_set_if wr ();

  lcd_position_set dut (
    .clk             (clk),
    .rst             (rst),
    .position_en     (position_en),
    .x_start         (x_start),
    .x_end           (x_end),
    .y_start         (y_start),
    .y_end           (y_end),
    .wr              (wr.master),
    .busy            (busy),
    .position_finish (position_finish),
    .pix_total       (pix_total),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t_start = 0;
  int         fin_cnt = 0;
  int         hold63 = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte = 9'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_req", {31'd0, wr.wr_req}, 32'd1);
        check("hold_byte", {23'd0, wr.wr_dc, wr.wr_data}, {23'd0, prev_byte});
      end
      if (wr.wr_req && wr.wr_ready) got_q.push_back({wr.wr_dc, wr.wr_data});
      if (wr.wr_req && wr.wr_data == 8'h63) hold63++;
      if (position_finish) fin_cnt++;
      prev_stall = wr.wr_req && !wr.wr_ready;
      prev_byte  = {wr.wr_dc, wr.wr_data};
    end
  end

  // driver tasks
  task automatic set_win(input logic [15:0] xs, input logic [15:0] xe,
                         input logic [15:0] ys, input logic [15:0] ye);
    x_start = xs; x_end = xe; y_start = ys; y_end = ye;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    fin_cnt = 0;
    hold63  = 0;
  endtask

  task automatic start_seq();
    @(posedge clk); #1;
    position_en = 1'b1;
    t_start = cyc;
  endtask

  task automatic stop_en();
    @(posedge clk); #1;
    position_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_finish(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 200 && lat < 0) begin
      @(negedge clk);
      if (position_finish) lat = cyc - t_start;
      n++;
    end
    if (lat < 0) check("finish_timeout", 32'd0, 32'd1);
  endtask

  // expected bytes from hand-normalised window bounds
  task automatic push_exp(input logic [15:0] xs, input logic [15:0] xe,
                          input logic [15:0] ys, input logic [15:0] ye, input int n);
    logic [8:0] seq[11];
    seq = '{{1'b0, 8'h2A}, {1'b1, xs[15:8]}, {1'b1, xs[7:0]}, {1'b1, xe[15:8]}, {1'b1, xe[7:0]},
            {1'b0, 8'h2B}, {1'b1, ys[15:8]}, {1'b1, ys[7:0]}, {1'b1, ye[15:8]}, {1'b1, ye[7:0]},
            {1'b0, 8'h2C}};
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, {23'd0, got_q.pop_front()}, {23'd0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    position_en = 1'b0;
    wr.wr_ready = 1'b1;
    set_win(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req", {31'd0, wr.wr_req}, 32'd0);
    check("rst_dc", {31'd0, wr.wr_dc}, 32'd0);
    check("rst_data", {24'd0, wr.wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_finish", {31'd0, position_finish}, 32'd0);
    check("rst_pix", pix_total, 32'd0);

    // basic window; coordinate changes after the start edge must be ignored
    clear_mon();
    set_win(16'd10, 16'd99, 16'd20, 16'd49);
    start_seq();
    @(posedge clk); #1;
    set_win(16'd7, 16'd3, 16'd300, 16'd1);
    wait_finish(lat);
    check("basic_latency", lat, 32'd13);
    check("basic_pix", pix_total, 32'd2700);
    @(negedge clk);
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("basic_fin_cnt", fin_cnt, 32'd1);
    check("basic_hold63", hold63, 32'd1);
    push_exp(16'd10, 16'd99, 16'd20, 16'd49, 11);
    check_bytes("basic");
    stop_en();

    // swapped and oversize x
    clear_mon();
    set_win(16'd300, 16'd5, 16'd0, 16'd0);
    start_seq();
    wait_finish(lat);
    check("swap_latency", lat, 32'd13);
    check("swap_pix", pix_total, 32'd235);
    push_exp(16'd5, 16'd239, 16'd0, 16'd0, 11);
    check_bytes("swap");
    stop_en();

    // wr_ready low for 3 cycles while byte 4 is offered
    clear_mon();
    set_win(16'd10, 16'd99, 16'd20, 16'd49);
    start_seq();
    repeat (6) @(posedge clk);
    #1 wr.wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 wr.wr_ready = 1'b1;
    wait_finish(lat);
    check("stall_latency", lat, 32'd16);
    check("stall_hold63", hold63, 32'd4);
    repeat (2) @(negedge clk);
    check("stall_fin_cnt", fin_cnt, 32'd1);
    push_exp(16'd10, 16'd99, 16'd20, 16'd49, 11);
    check_bytes("stall");
    stop_en();

    // abort: position_en drops while byte 6 is stalled
    clear_mon();
    start_seq();
    repeat (8) @(posedge clk);
    #1;
    wr.wr_ready = 1'b0;
    position_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 wr.wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_req", {31'd0, wr.wr_req}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_fin_cnt", fin_cnt, 32'd0);
    push_exp(16'd10, 16'd99, 16'd20, 16'd49, 7);
    check_bytes("abort");

    // reset while byte 8 is offered, then a full replay
    clear_mon();
    start_seq();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    position_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req", {31'd0, wr.wr_req}, 32'd0);
    check("mid_rst_dc", {31'd0, wr.wr_dc}, 32'd0);
    check("mid_rst_data", {24'd0, wr.wr_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_pix", pix_total, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    push_exp(16'd10, 16'd99, 16'd20, 16'd49, 8);
    check_bytes("pre_rst");
    clear_mon();
    start_seq();
    wait_finish(lat);
    check("replay_latency", lat, 32'd13);
    check("replay_pix", pix_total, 32'd2700);
    push_exp(16'd10, 16'd99, 16'd20, 16'd49, 11);
    check_bytes("replay");
    stop_en();

    // position_en held high for 40 cycles; y clamped at the bottom edge
    clear_mon();
    set_win(16'd0, 16'd239, 16'd318, 16'd500);
    start_seq();
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("held_fin_cnt", fin_cnt, 32'd1);
    check("held_pix", pix_total, 32'd480);
    check("held_busy", {31'd0, busy}, 32'd0);
    push_exp(16'd0, 16'd239, 16'd318, 16'd319, 11);
    check_bytes("held");
    stop_en();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
